exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
Execute/write-back stage sitting directly downstream of the register file. Consumes the two read operands (v1, v2) plus a decoded op and destination, and computes the result. Drives the register file write port (write select + write data) as a one-cycle write-back pulse. Single-cycle logic ops; iterative shift-add MUL and bit-serial SLL hold off new work via a ready handshake.

Parameters:
N, 32, datapath width; must match register file width.
AW, 2, register address width (4 architectural registers).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
in_valid  input  1  op/operands valid this cycle
in_ready  output  1  stage can accept an op this cycle
op  input  3  operation code (see Behaviour)
dst  input  AW  destination register index
a  input  N  operand A (from register file v1)
b  input  N  operand B (from register file v2)
wsel  output  AW+1  register file write select; MSB=1 means no write (3'b100 for AW=2)
wdata  output  N  register file write data
busy  output  1  multi-cycle op in progress (equals !in_ready)

Behaviour:
- Reset (rst=0, async): state=IDLE, in_ready=1, busy=0, wsel={1'b1,AW'b0}, wdata=0, iteration counter=0, operand registers=0.
- Op codes: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 PASS (a), 6 SLL (a << b[$clog2(N)-1:0]), 7 MUL (low N bits of a*b). All arithmetic modulo 2^N; carries and overflow discarded.
- Accept: a rising edge with in_valid=1 and in_ready=1 is the acceptance edge E0. in_valid while in_ready=0 is ignored; no queueing, and upstream may drop it.
- Write-back pulse: wsel={1'b0,dst}, wdata=result for exactly one cycle. Otherwise wsel=no-write, and wdata holds its last value.
- Ops 0-5, and SLL with shift amount 0: result registered at E0. Write-back visible in the cycle after E0. State stays IDLE and in_ready stays 1, so back-to-back ops issue every cycle.
- MUL: E0 latches a, b, dst and sets counter=N, state=ITER, in_ready=0. Each later edge performs one shift-add step (if b_reg[0], acc+=a_reg; a_reg<<=1; b_reg>>=1) and decrements the counter. The edge where the counter reaches 0 (E_N) registers the write-back and returns to IDLE with in_ready=1. No early termination when b_reg becomes 0; latency is fixed.
- SLL with k>0: same flow, one bit per edge, counter=k. Write-back registered at E_k.
- Exactly one write-back per accepted op. Never a write-back without an acceptance.
- Reset mid-ITER: op aborted, no write-back, outputs at reset values.
- ITER state never accepts: an op presented on the completing edge E_N is not taken. It is accepted on the next edge if in_valid is still 1.

Optional Feature:
EXEC_FLAGS_EN: adds outputs zero (1) and carry (1), registered together with every write-back.
- zero = (result==0).
- carry = carry-out of ADD, or borrow of SUB (a<b unsigned); 0 for all other ops.
- Flags hold their value until the next write-back. Reset value 0.
Without the macro: ports absent; no flag logic.

Decomposition:
- Package exec_pkg holds: op_t enum (OP_ADD..OP_MUL), WSEL_NONE constant, and state_t enum {IDLE, ITER}.
- One sub-module, exec_alu: purely combinational ops 0-5 plus optional carry. exec_unit owns the handshake, the FSM, and the MUL/SLL iteration datapath.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 -> wsel=3'b100, wdata=0, in_ready=1. No write-back while in_valid=0.
- ALU burst, back-to-back: ADD a=3 b=5 dst=1, then SUB a=0 b=1 dst=2, then XOR a=32'hF0F0F0F0 b=32'hFFFFFFFF dst=3 on consecutive cycles -> write-backs on 3 consecutive cycles: (1,8), (2,32'hFFFFFFFF), (3,32'h0F0F0F0F).
- MUL: a=7 b=6 dst=0 -> in_ready=0 for 32 cycles; single write-back (0,42) exactly N=32 edges after E0. a=32'hFFFFFFFF b=2 -> 32'hFFFFFFFE.
- SLL: a=1 b=4 dst=2 -> write-back (2,16) after 4 edges. b=0 -> (2,1) the next cycle with in_ready staying 1. b=32'h25 -> shift 5, result 32.
- Busy/abort: issue ADD during MUL ITER -> ignored, no extra write-back. Assert rst=0 mid-MUL -> no write-back, clean IDLE afterwards.
- With EXEC_FLAGS_EN: ADD 32'hFFFFFFFF+1 -> wdata=0, zero=1, carry=1. SUB 2-3 -> carry=1, zero=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute/write-back stage: op codes, FSM states, write-select encoding.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_PASS = 3'd5,
        OP_SLL  = 3'd6,
        OP_MUL  = 3'd7
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    // Write select with MSB set means "no register file write" (4-register file).
    localparam logic [2:0] WSEL_NONE = 3'b100;

endpackage

// File: rtl/exec_alu.sv
// Combinational single-cycle ops (ADD..PASS); carry/borrow output only with EXEC_FLAGS_EN.
// Latency 0, no state, no backpressure.
module exec_alu
    import exec_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef EXEC_FLAGS_EN
    output logic         carry,
`endif
    output logic [N-1:0] result
);

    always_comb begin
        result = '0;
        case (op_t'(op))
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_PASS: result = a;
            default: result = '0;
        endcase
    end

`ifdef EXEC_FLAGS_EN
    logic [N-1:0] sum;

    // Unsigned wrap of the sum is exactly the carry-out.
    always_comb begin
        sum   = a + b;
        carry = 1'b0;
        case (op_t'(op))
            OP_ADD:  carry = (sum < a);
            OP_SUB:  carry = (a < b);
            default: carry = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/exec_unit.sv
// Execute/write-back stage: 1-cycle logic ops, iterative MUL (N edges) and SLL (k edges); optional flags via EXEC_FLAGS_EN.
// Latency: write-back visible the cycle after the completing edge (E0 for single-cycle ops, E_N / E_k for MUL / SLL).
// Backpressure: in_ready drops while iterating; ops offered while not ready are ignored, not queued.
module exec_unit
    import exec_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] dst,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic [AW:0]   wsel,
    output logic [N-1:0]  wdata,
`ifdef EXEC_FLAGS_EN
    output logic          zero,
    output logic          carry,
`endif
    output logic          busy
);

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam logic [AW:0] NO_WRITE = {1'b1, {AW{1'b0}}};

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   acc, a_reg, b_reg;
    logic [AW-1:0]  dst_reg;
    logic           is_mul;

    logic [SW-1:0]  shamt;
    logic           is_mul_op, is_sll_op;
    logic           accept, start_iter, last_step;
    logic [N-1:0]   alu_res, imm_res, step_acc;
`ifdef EXEC_FLAGS_EN
    logic           alu_carry;
`endif

    exec_alu #(.N(N)) u_alu (
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef EXEC_FLAGS_EN
        .carry  (alu_carry),
`endif
        .result (alu_res)
    );

    assign shamt      = b[SW-1:0];
    assign is_mul_op  = (op_t'(op) == OP_MUL);
    assign is_sll_op  = (op_t'(op) == OP_SLL);
    assign accept     = in_valid && (state == IDLE);
    // A zero-distance shift completes like any single-cycle op.
    assign start_iter = accept && (is_mul_op || (is_sll_op && (shamt != '0)));
    assign last_step  = (state == ITER) && (cnt == CW'(1));
    assign imm_res    = is_sll_op ? a : alu_res;

    // MUL: shift-add on acc; SLL: acc holds the operand and shifts one bit per edge.
    always_comb begin
        step_acc = acc << 1;
        if (is_mul) begin
            step_acc = b_reg[0] ? (acc + a_reg) : acc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_iter) state_nxt = ITER;
            ITER:    if (last_step)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == ITER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            acc     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            dst_reg <= '0;
            is_mul  <= 1'b0;
            wsel    <= NO_WRITE;
            wdata   <= '0;
`ifdef EXEC_FLAGS_EN
            zero    <= 1'b0;
            carry   <= 1'b0;
`endif
        end else begin
            wsel <= NO_WRITE;
            if (start_iter) begin
                dst_reg <= dst;
                is_mul  <= is_mul_op;
                a_reg   <= a;
                b_reg   <= b;
                acc     <= is_mul_op ? '0 : a;
                cnt     <= is_mul_op ? CW'(N) : CW'(shamt);
            end else if (accept) begin
                wsel  <= {1'b0, dst};
                wdata <= imm_res;
`ifdef EXEC_FLAGS_EN
                zero  <= (imm_res == '0);
                carry <= alu_carry;
`endif
            end else if (state == ITER) begin
                acc   <= step_acc;
                a_reg <= a_reg << 1;
                b_reg <= b_reg >> 1;
                cnt   <= cnt - CW'(1);
                if (last_step) begin
                    wsel  <= {1'b0, dst_reg};
                    wdata <= step_acc;
`ifdef EXEC_FLAGS_EN
                    zero  <= (step_acc == '0);
                    carry <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed literal cases plus randomized traffic against a cycle-level behavioural model.
module tb_exec_unit;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [1:0]  dst = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready, busy;
    logic [2:0]  wsel;
    logic [31:0] wdata;
`ifdef EXEC_FLAGS_EN
    logic        zero, carry;
`endif

    exec_unit #(.N(32), .AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .dst      (dst),
        .a        (a),
        .b        (b),
        .wsel     (wsel),
        .wdata    (wdata),
`ifdef EXEC_FLAGS_EN
        .zero     (zero),
        .carry    (carry),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference semantics from the op table.
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return x;
            3'd6: return x << y[4:0];
            default: return x * y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] y);
        if (o == 3'd7) return 32;
        if (o == 3'd6) return int'(y[4:0]);
        return 0;
    endfunction

    function automatic logic ref_carry(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (o == 3'd0) return s[32];
        if (o == 3'd1) return (x < y);
        return 1'b0;
    endfunction

    // Model: edge counter, earliest edge allowed to accept, and one pending write-back.
    int          e = 0, free_e = 0, pend_e = 0, lat_m;
    bit          pend = 1'b0;
    logic [1:0]  pend_dst;
    logic [31:0] pend_data, res_m;
    logic [2:0]  exp_wsel = 3'b100;
    logic [31:0] exp_wdata = 32'd0;
    logic        exp_ready = 1'b1, exp_zero = 1'b0, exp_carry = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e = 0; free_e = 0; pend = 1'b0;
            exp_wsel = 3'b100; exp_wdata = 32'd0; exp_ready = 1'b1;
            exp_zero = 1'b0; exp_carry = 1'b0;
        end else begin
            e++;
            exp_wsel = 3'b100;
            if (pend && pend_e == e) begin
                exp_wsel  = {1'b0, pend_dst};
                exp_wdata = pend_data;
                exp_zero  = (pend_data == 32'd0);
                exp_carry = 1'b0;
                pend      = 1'b0;
            end
            if (in_valid && e >= free_e) begin
                res_m = ref_res(op, a, b);
                lat_m = ref_lat(op, b);
                if (lat_m == 0) begin
                    exp_wsel  = {1'b0, dst};
                    exp_wdata = res_m;
                    exp_zero  = (res_m == 32'd0);
                    exp_carry = ref_carry(op, a, b);
                end else begin
                    pend = 1'b1; pend_e = e + lat_m; pend_dst = dst; pend_data = res_m;
                    free_e = e + lat_m + 1;
                end
            end
            exp_ready = (e + 1 >= free_e);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, exp_ready);
            chk("busy", busy, !exp_ready);
            chk("wsel", wsel, exp_wsel);
            chk("wdata", wdata, exp_wdata);
`ifdef EXEC_FLAGS_EN
            chk("zero", zero, exp_zero);
            chk("carry", carry, exp_carry);
`endif
        end
    end

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] o, input logic [1:0] d, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1; op = o; dst = d; a = x; b = y;
    endtask

    // Issue one op, then wait (bounded) for its write-back and check value and cycle count.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [1:0] d,
                          input logic [31:0] x, input logic [31:0] y, input int lat, input logic [31:0] exp_data);
        int c;
        drive(o, d, x, y);
        tick;
        in_valid = 1'b0;
        c = 1;
        while (wsel[2] && c < 100) begin
            tick;
            c++;
        end
        chk({nm, "_wsel"}, wsel, {1'b0, d});
        chk({nm, "_wdata"}, wdata, exp_data);
        chk({nm, "_lat"}, c, lat + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, nwb;
        tick;
        chk_en = 1'b1;
        chk("rst_wsel", wsel, 3'b100);
        chk("rst_wdata", wdata, 32'd0);
        tick;
        rst = 1'b1;
        tick;
        chk("idle_wsel", wsel, WSEL_NONE);
        chk("idle_ready", in_ready, 1'b1);
        nwb = 0;
        repeat (4) begin tick; if (!wsel[2]) nwb++; end
        chk("idle_no_wb", nwb, 0);

        // Back-to-back ALU burst
        drive(3'd0, 2'd1, 32'd3, 32'd5);
        tick;
        chk("burst_add", {wsel, wdata}, {3'b001, 32'd8});
        drive(3'd1, 2'd2, 32'd0, 32'd1);
        tick;
        chk("burst_sub", {wsel, wdata}, {3'b010, 32'hFFFFFFFF});
        drive(3'd4, 2'd3, 32'hF0F0F0F0, 32'hFFFFFFFF);
        tick;
        chk("burst_xor", {wsel, wdata}, {3'b011, 32'h0F0F0F0F});
        in_valid = 1'b0;
        tick;

        // MUL: ready held low for exactly N cycles, write-back on completion
        drive(3'd7, 2'd0, 32'd7, 32'd6);
        tick;
        in_valid = 1'b0;
        c = 0;
        while (!in_ready && c < 100) begin tick; c++; end
        chk("mul_busy_cycles", c, 32);
        chk("mul_wb", {wsel, wdata}, {3'b000, 32'd42});
        tick;
        run_op("mul_wrap", 3'd7, 2'd1, 32'hFFFFFFFF, 32'd2, 32, 32'hFFFFFFFE);
        run_op("sll4", 3'd6, 2'd2, 32'd1, 32'd4, 4, 32'd16);
        run_op("sll0", 3'd6, 2'd2, 32'd1, 32'd0, 0, 32'd1);
        chk("sll0_ready", in_ready, 1'b1);
        run_op("sll25", 3'd6, 2'd3, 32'd1, 32'h25, 5, 32'd32);

        // ADD offered mid-iteration must be dropped
        drive(3'd7, 2'd0, 32'd7, 32'd6);
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        drive(3'd0, 2'd3, 32'd1, 32'd1);
        tick;
        in_valid = 1'b0;
        nwb = 0;
        c = 0;
        while (wsel[2] && c < 100) begin tick; c++; end
        chk("busy_ignore_wb", {wsel, wdata}, {3'b000, 32'd42});
        repeat (5) begin tick; if (!wsel[2]) nwb++; end
        chk("busy_no_extra", nwb, 0);

        // Reset in the middle of a MUL
        drive(3'd7, 2'd1, 32'd9, 32'd9);
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        rst = 1'b0;
        tick;
        chk("abort_state", {in_ready, busy, wsel, wdata}, {1'b1, 1'b0, 3'b100, 32'd0});
        tick;
        rst = 1'b1;
        nwb = 0;
        repeat (40) begin tick; if (!wsel[2]) nwb++; end
        chk("abort_no_wb", nwb, 0);

`ifdef EXEC_FLAGS_EN
        run_op("flag_add", 3'd0, 2'd1, 32'hFFFFFFFF, 32'd1, 0, 32'd0);
        chk("flag_add_zc", {zero, carry}, 2'b11);
        run_op("flag_sub", 3'd1, 2'd2, 32'd2, 32'd3, 0, 32'hFFFFFFFF);
        chk("flag_sub_zc", {zero, carry}, 2'b01);
`endif

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            op  = 3'($urandom_range(0, 7));
            dst = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            tick;
        end
        in_valid = 1'b0;
        repeat (40) tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
